// File: rtl/exam_result_capture_if.sv
// Start/done handshake and result bus from the exam compute block into
// exam_result_capture.
interface exam_result_capture_if #(
   parameter int DATA_W = 16
);
   logic              start;
   logic              done;
   logic [DATA_W-1:0] g;
   logic [DATA_W-1:0] h;

   modport master (output start, done, g, h);
   modport slave  (input  start, done, g, h);
endinterface

// File: rtl/exam_result_capture.sv
// Captures g/h on the first done after a start edge, measures start->done latency,
// flags timeouts and drives a pushbutton-selected display word.
// Optional build macro RESULT_PARITY_EN adds registered parity bits of g_q/h_q to the status word.
module exam_result_capture #(
   parameter int DATA_W      = 16,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT     = 50000,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   exam_result_capture_if.slave  res_if,
   input  logic                  key_n,
   output logic [DATA_W-1:0]     disp,
   output logic [1:0]            sel,
   output logic                  valid,
   output logic                  timeout,
   output logic [CNT_W-1:0]      latency
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HOLD,
      S_TOUT
   } state_t;

   state_t                 state_q, state_d;
   logic                   start_d_q, start_d_d;
   logic                   armed_q, armed_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0]      g_q, g_d;
   logic [DATA_W-1:0]      h_q, h_d;
   logic [CNT_W-1:0]       latency_q, latency_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   key_prev_q, key_prev_d;
   logic [1:0]             sel_q, sel_d;
   logic [DATA_W-1:0]      disp_q, disp_d;

   logic                   start_rise;
   logic                   capture;
   logic                   key_s;
   logic                   press;
   logic                   par_g, par_h;
   logic [DATA_W-1:0]      lat_ext;
   logic [DATA_W-1:0]      status;

   // A start that is already high when reset releases is not a new request:
   // edges only count once start has been seen low.
   assign start_d_d  = res_if.start;
   assign armed_d    = armed_q | ~res_if.start;
   assign start_rise = res_if.start & ~start_d_q & armed_q;

   // ---------------------------------------------------------------------
   // Measurement FSM: next state, counter and capture
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      state_d   = state_q;
      cnt_d     = cnt_q;
      g_d       = g_q;
      h_d       = h_q;
      latency_d = latency_q;
      capture   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start_rise) begin
               if (res_if.done) begin
                  state_d   = S_HOLD;
                  capture   = 1'b1;
                  latency_d = '0;
               end else begin
                  state_d = S_RUN;
               end
            end
         end

         S_RUN: begin
            if (!res_if.start) begin
               // Abandoned measurement: count is dropped, earlier captures stay.
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (res_if.done) begin
               state_d   = S_HOLD;
               capture   = 1'b1;
               latency_d = cnt_q;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d   = S_TOUT;
               latency_d = CNT_W'(TIMEOUT);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_HOLD: begin
            if (!res_if.start) state_d = S_IDLE;
         end

         S_TOUT: begin
            if (!res_if.start) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      if (capture) begin
         g_d = res_if.g;
         h_d = res_if.h;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q   <= S_IDLE;
         start_d_q <= 1'b0;
         armed_q   <= 1'b0;
         cnt_q     <= '0;
         g_q       <= '0;
         h_q       <= '0;
         latency_q <= '0;
      end else begin
         state_q   <= state_d;
         start_d_q <= start_d_d;
         armed_q   <= armed_d;
         cnt_q     <= cnt_d;
         g_q       <= g_d;
         h_q       <= h_d;
         latency_q <= latency_d;
      end
   end

   assign valid   = (state_q == S_HOLD);
   assign timeout = (state_q == S_TOUT);
   assign latency = latency_q;

   // ---------------------------------------------------------------------
   // Optional result parity, taken from the values being captured
   // ---------------------------------------------------------------------
`ifdef RESULT_PARITY_EN
   logic par_g_q, par_g_d;
   logic par_h_q, par_h_d;

   always_comb begin
      par_g_d = par_g_q;
      par_h_d = par_h_q;
      if (capture) begin
         par_g_d = ^res_if.g;
         par_h_d = ^res_if.h;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_g_q <= 1'b0;
         par_h_q <= 1'b0;
      end else begin
         par_g_q <= par_g_d;
         par_h_q <= par_h_d;
      end
   end

   assign par_g = par_g_q;
   assign par_h = par_h_q;
`else
   assign par_g = 1'b0;
   assign par_h = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Pushbutton synchroniser and display select
   // ---------------------------------------------------------------------
   assign sync_d     = {sync_q[SYNC_STAGES-2:0], key_n};
   assign key_s      = sync_q[SYNC_STAGES-1];
   assign key_prev_d = key_s;
   assign press      = key_prev_q & ~key_s;
   assign sel_d      = press ? sel_q + 2'd1 : sel_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '1;
         key_prev_q <= 1'b1;
         sel_q      <= '0;
      end else begin
         sync_q     <= sync_d;
         key_prev_q <= key_prev_d;
         sel_q      <= sel_d;
      end
   end

   assign sel = sel_q;

   // ---------------------------------------------------------------------
   // Registered display mux
   // ---------------------------------------------------------------------
   always_comb begin
      lat_ext             = '0;
      lat_ext[CNT_W-1:0]  = latency_q;
      status              = '0;
      status[3:0]         = {timeout, valid, par_h, par_g};

      unique case (sel_q)
         2'd0:    disp_d = g_q;
         2'd1:    disp_d = h_q;
         2'd2:    disp_d = lat_ext;
         default: disp_d = status;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) disp_q <= '0;
      else        disp_q <= disp_d;
   end

   assign disp = disp_q;

endmodule
